// File: rtl/godai_trace_capture.sv
// godai_trace_capture: snoops fetch handshakes, forms timestamped trace records and buffers them in a FIFO
module godai_trace_capture #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TS_WIDTH   = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          instr_req_i,
  input  logic                          instr_gnt_i,
  input  logic                          instr_rvalid_i,
  input  logic [ADDR_WIDTH-1:0]         instr_addr_i,
  input  logic [DATA_WIDTH-1:0]         instr_rdata_i,
  input  logic                          branch_req_i,
  input  logic                          branch_decision_i,
  input  logic                          illegal_instr_i,
  output logic                          trace_valid_o,
  input  logic                          trace_ready_i,
  output logic [ADDR_WIDTH-1:0]         trace_addr_o,
  output logic [DATA_WIDTH-1:0]         trace_instr_o,
  output logic [TS_WIDTH-1:0]           trace_ts_o,
  output logic [3:0]                    trace_flags_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int RW = ADDR_WIDTH + DATA_WIDTH + TS_WIDTH + 4;
  typedef enum logic {IDLE, WAIT_RV} state_t;
  state_t state;
  logic [TS_WIDTH-1:0] ts, pend_ts;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic wrap_sticky, drop_sticky, br_sticky, ill_sticky;
  logic [RW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic fetch, push, pop, push_ok, br_now, ill_now;
  logic [RW-1:0] rec;
  assign fetch = instr_req_i & instr_gnt_i;
  assign push = (state == WAIT_RV) & instr_rvalid_i;
  assign pop = trace_valid_o & trace_ready_i;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok = push & ((level != LW'(FIFO_DEPTH)) | pop);
  // the rvalid cycle itself contributes to the branch/illegal flags
  assign br_now = br_sticky | (branch_req_i & branch_decision_i);
  assign ill_now = ill_sticky | illegal_instr_i;
  assign rec = {pend_addr, instr_rdata_i, pend_ts, wrap_sticky, drop_sticky, ill_now, br_now};
  assign trace_valid_o = level != '0;
  // outputs are forced to zero when empty so reset clears them without resetting the storage
  assign {trace_addr_o, trace_instr_o, trace_ts_o, trace_flags_o} = trace_valid_o ? mem[rd_ptr] : '0;
  assign level_o = level;
  // free-running timestamp; wrap flag held until a record carries it out
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ts <= '0;
      wrap_sticky <= 1'b0;
    end else begin
      ts <= ts + 1'b1;
      wrap_sticky <= (&ts) | (wrap_sticky & ~push_ok);
    end
  // single outstanding fetch tracker; a new grant always replaces the pending slot
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pend_addr <= '0;
      pend_ts <= '0;
      br_sticky <= 1'b0;
      ill_sticky <= 1'b0;
    end else if (fetch) begin
      state <= WAIT_RV;
      pend_addr <= instr_addr_i;
      pend_ts <= ts;
      br_sticky <= 1'b0;
      ill_sticky <= 1'b0;
    end else begin
      br_sticky <= (state == WAIT_RV) ? br_now : br_sticky;
      ill_sticky <= (state == WAIT_RV) ? ill_now : ill_sticky;
      state <= push ? IDLE : state;
    end
  // FIFO pointers, occupancy and drop reporting
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      overflow_o <= 1'b0;
      drop_sticky <= 1'b0;
    end else begin
      wr_ptr <= push_ok ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      level <= level + LW'(push_ok) - LW'(pop);
      overflow_o <= push & ~push_ok;
      drop_sticky <= push ? ~push_ok : drop_sticky;
    end
  // record storage
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= rec;
endmodule

// File: tb/tb_godai_trace_capture.sv
// tb_godai_trace_capture: directed and randomized checks of the trace capture block against a queue model
module tb_godai_trace_capture;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic instr_req_i = 1'b0, instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0;
  logic [31:0] instr_addr_i = '0, instr_rdata_i = '0;
  logic branch_req_i = 1'b0, branch_decision_i = 1'b0, illegal_instr_i = 1'b0;
  logic trace_ready_i = 1'b0;
  logic trace_valid_o, overflow_o;
  logic [31:0] trace_addr_o, trace_instr_o;
  logic [3:0] trace_ts_o, trace_flags_o;
  logic [4:0] level_o;
  godai_trace_capture #(.TS_WIDTH(4), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(instr_req_i), .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
    .instr_addr_i(instr_addr_i), .instr_rdata_i(instr_rdata_i),
    .branch_req_i(branch_req_i), .branch_decision_i(branch_decision_i), .illegal_instr_i(illegal_instr_i),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_addr_o(trace_addr_o), .trace_instr_o(trace_instr_o), .trace_ts_o(trace_ts_o),
    .trace_flags_o(trace_flags_o), .overflow_o(overflow_o), .level_o(level_o)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] a; logic [31:0] i; logic [3:0] t; logic [3:0] f;} rec_t;
  rec_t q[$];
  int vectors = 0, miscompares = 0, ovf_seen = 0, cyc = 0;
  bit outst, m_br, m_ill, m_wrap, m_drop, exp_ovf;
  logic [31:0] m_addr;
  logic [3:0] m_ts;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // reference: one record per fetch, flags gathered between grant and data, FIFO of 16
  task automatic model_edge();
    bit pop, push, acc;
    rec_t r;
    logic [3:0] now;
    now = 4'(cyc);
    pop = (q.size() != 0) && trace_ready_i;
    push = outst && instr_rvalid_i;
    acc = (q.size() < 16) || pop;
    exp_ovf = 0;
    r.a = m_addr; r.i = instr_rdata_i; r.t = m_ts;
    r.f = {m_wrap, m_drop, m_ill | illegal_instr_i, m_br | (branch_req_i & branch_decision_i)};
    if (pop) void'(q.pop_front());
    if (push && acc) begin q.push_back(r); m_wrap = 0; m_drop = 0; end
    if (push && !acc) begin m_drop = 1; exp_ovf = 1; end
    if (now == 4'hf) m_wrap = 1;
    if (outst) begin m_br |= branch_req_i & branch_decision_i; m_ill |= illegal_instr_i; end
    if (instr_req_i && instr_gnt_i) begin
      outst = 1; m_addr = instr_addr_i; m_ts = now; m_br = 0; m_ill = 0;
    end else if (push) outst = 0;
    cyc++;
  endtask
  task automatic step();
    model_edge();
    @(posedge clk); #1;
    if (overflow_o === 1'b1) ovf_seen++;
    chk("valid", trace_valid_o, q.size() != 0);
    chk("level", level_o, q.size());
    chk("overflow", overflow_o, exp_ovf);
    if (q.size() != 0) begin
      chk("addr", trace_addr_o, q[0].a);
      chk("instr", trace_instr_o, q[0].i);
      chk("ts", trace_ts_o, q[0].t);
      chk("flags", trace_flags_o, q[0].f);
    end
  endtask
  task automatic go(input bit req, gnt, rv, input logic [31:0] a, d, input bit breq, bdec, ill, rdy);
    instr_req_i = req; instr_gnt_i = gnt; instr_rvalid_i = rv;
    instr_addr_i = a; instr_rdata_i = d;
    branch_req_i = breq; branch_decision_i = bdec; illegal_instr_i = ill;
    trace_ready_i = rdy;
    step();
  endtask
  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) go(0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    instr_req_i = 0; instr_gnt_i = 0; instr_rvalid_i = 0;
    branch_req_i = 0; branch_decision_i = 0; illegal_instr_i = 0; trace_ready_i = 0;
    #1;
    chk("rst_valid", trace_valid_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_addr", trace_addr_o, 0);
    chk("rst_instr", trace_instr_o, 0);
    chk("rst_ts", trace_ts_o, 0);
    chk("rst_flags", trace_flags_o, 0);
    chk("rst_ovf", overflow_o, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
    cyc = 0; outst = 0; m_br = 0; m_ill = 0; m_wrap = 0; m_drop = 0;
  endtask
  initial begin
    do_reset();
    // single fetch granted at ts=5
    idle(5, 1);
    go(1, 1, 0, 32'h20, 0, 0, 0, 0, 1);
    idle(1, 1);
    go(0, 0, 1, 0, 32'h13, 0, 0, 0, 1);
    chk("t1_valid", trace_valid_o, 1);
    chk("t1_addr", trace_addr_o, 32'h20);
    chk("t1_instr", trace_instr_o, 32'h13);
    chk("t1_ts", trace_ts_o, 5);
    chk("t1_flags", trace_flags_o, 0);
    // back-to-back: data for 0x20 arrives with grant of 0x24
    do_reset();
    go(1, 1, 0, 32'h20, 0, 0, 0, 0, 0);
    idle(1, 0);
    go(1, 1, 1, 32'h24, 32'haaaa, 0, 0, 0, 0);
    go(0, 0, 1, 0, 32'hbbbb, 0, 0, 0, 0);
    chk("t2_level", level_o, 2);
    chk("t2_addr0", trace_addr_o, 32'h20);
    chk("t2_ts0", trace_ts_o, 0);
    idle(1, 1);
    chk("t2_addr1", trace_addr_o, 32'h24);
    chk("t2_ts1", trace_ts_o, 2);
    // branch and illegal flags
    do_reset();
    go(1, 1, 0, 32'h40, 0, 0, 0, 0, 0);
    go(0, 0, 0, 0, 0, 1, 1, 0, 0);
    idle(1, 0);
    go(0, 0, 1, 0, 32'h1234, 0, 0, 1, 0);
    chk("t4_flags", trace_flags_o, 4'b0011);
    // timestamp wrap flag on exactly one record
    do_reset();
    idle(17, 1);
    go(1, 1, 0, 32'h50, 0, 0, 0, 0, 1);
    go(0, 0, 1, 0, 32'h55, 0, 0, 0, 1);
    chk("t5_ts", trace_ts_o, 1);
    chk("t5_wrap", trace_flags_o[3], 1);
    go(1, 1, 0, 32'h54, 0, 0, 0, 0, 1);
    go(0, 0, 1, 0, 32'h66, 0, 0, 0, 1);
    chk("t5_addr2", trace_addr_o, 32'h54);
    chk("t5_nowrap", trace_flags_o[3], 0);
    // overflow: 17 fetches into a 16-entry FIFO with the sink stalled
    do_reset();
    ovf_seen = 0;
    for (int k = 0; k < 17; k++) begin
      go(1, 1, 0, 32'h100 + 32'(4 * k), 0, 0, 0, 0, 0);
      go(0, 0, 1, 0, 32'(k), 0, 0, 0, 0);
    end
    idle(2, 0);
    chk("t3_level", level_o, 16);
    chk("t3_pulses", ovf_seen, 1);
    idle(16, 1);
    chk("t3_drained", level_o, 0);
    go(1, 1, 0, 32'h200, 0, 0, 0, 0, 0);
    go(0, 0, 1, 0, 32'h77, 0, 0, 0, 0);
    chk("t3_next_addr", trace_addr_o, 32'h200);
    chk("t3_drop_flag", trace_flags_o[2], 1);
    // reset while waiting for data with records queued
    do_reset();
    for (int k = 0; k < 3; k++) begin
      go(1, 1, 0, 32'h300 + 32'(4 * k), 0, 0, 0, 0, 0);
      go(0, 0, 1, 0, 32'(k), 0, 0, 0, 0);
    end
    go(1, 1, 0, 32'h30c, 0, 0, 0, 0, 0);
    chk("t6_level_pre", level_o, 3);
    do_reset();
    go(0, 0, 1, 0, 32'hdead, 0, 0, 0, 1);
    chk("t6_late_rv", level_o, 0);
    // randomized traffic: stalled sink first, then mostly ready
    do_reset();
    for (int k = 0; k < 800; k++)
      go($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom,
         $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7) == 0,
         (k < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
